i2c_codec_target: RTL and testbench

Synthesizable I2C target (responder) that decodes the 3-byte WM8731 control-write frames an I2C initiator emits: device-address byte, then {reg_addr[6:0], data[8]}, then data[7:0]. Used as an on-chip stand-in for the codec control port in loopback builds and as the checker end of the initializer in system simulation. Oversamples SCL/SDA on the system clock, drives ACK on SDA open-drain, and emits one register-write strobe per completed frame.

---
 rtl/i2c_codec_target.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_codec_target.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target.sv
// I2C target that decodes 3-byte WM8731 control-write frames and strobes one register write per frame.
// Optional shadow register file enabled by defining I2C_TGT_SHADOW_EN.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic       o_reg_wr,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic       o_frame_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, OVER, IGNORE
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       sda_oe_reg, sda_oe_next;
    logic [6:0] addr_pend_reg, addr_pend_next;
    logic       d8_pend_reg, d8_pend_next;
    logic       reg_wr_reg, reg_wr_next;
    logic [6:0] reg_addr_reg, reg_addr_next;
    logic [8:0] reg_data_reg, reg_data_next;
    logic       frame_err_reg, frame_err_next;

    // Synchronizers reset to the idle-bus level so release from reset creates no phantom edges
    logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
    logic sda_meta_reg, sda_sync_reg, sda_prev_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_meta_reg <= 1'b1;
            scl_sync_reg <= 1'b1;
            scl_prev_reg <= 1'b1;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_meta_reg <= i_scl;
            scl_sync_reg <= scl_meta_reg;
            scl_prev_reg <= scl_sync_reg;
            sda_meta_reg <= io_sda;
            sda_sync_reg <= sda_meta_reg;
            sda_prev_reg <= sda_sync_reg;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, in_frame;

    assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
    assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
    assign start_det = ~sda_sync_reg & sda_prev_reg & scl_sync_reg & scl_prev_reg;
    assign stop_det  = sda_sync_reg & ~sda_prev_reg & scl_sync_reg & scl_prev_reg;
    assign in_frame  = (state_reg == ADDR) || (state_reg == BYTE1) || (state_reg == BYTE2) ||
                       (state_reg == ACK_A) || (state_reg == ACK_1) || (state_reg == ACK_2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sda_oe_reg    <= 1'b0;
            addr_pend_reg <= '0;
            d8_pend_reg   <= 1'b0;
            reg_wr_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_data_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            sda_oe_reg    <= sda_oe_next;
            addr_pend_reg <= addr_pend_next;
            d8_pend_reg   <= d8_pend_next;
            reg_wr_reg    <= reg_wr_next;
            reg_addr_reg  <= reg_addr_next;
            reg_data_reg  <= reg_data_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        sda_oe_next    = sda_oe_reg;
        addr_pend_next = addr_pend_reg;
        d8_pend_next   = d8_pend_reg;
        reg_wr_next    = 1'b0;
        reg_addr_next  = reg_addr_reg;
        reg_data_next  = reg_data_reg;
        frame_err_next = 1'b0;

        // STOP takes priority over START when both appear in one cycle
        if (stop_det) begin
            frame_err_next = in_frame;
            state_next     = IDLE;
            bit_cnt_next   = '0;
            sda_oe_next    = 1'b0;
        end else if (start_det) begin
            frame_err_next = in_frame;
            state_next     = ADDR;
            bit_cnt_next   = '0;
            sda_oe_next    = 1'b0;
        end else begin
            case (state_reg)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda_sync_reg};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == ADDR) begin
                                state_next = (shift_next == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                            end else if (state_reg == BYTE1) begin
                                addr_pend_next = shift_next[7:1];
                                d8_pend_next   = shift_next[0];
                                state_next     = ACK_1;
                            end else begin
                                reg_wr_next   = 1'b1;
                                reg_addr_next = addr_pend_reg;
                                reg_data_next = {d8_pend_reg, shift_next};
                                state_next    = ACK_2;
                            end
                        end
                    end
                end
                ACK_A, ACK_1, ACK_2: begin
                    // First SCL fall starts the ACK drive, the second ends it
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            case (state_reg)
                                ACK_A:   state_next = BYTE1;
                                ACK_1:   state_next = BYTE2;
                                default: state_next = OVER;
                            endcase
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_sda      = sda_oe_reg ? 1'b0 : 1'bz;
    assign o_reg_wr    = reg_wr_reg;
    assign o_reg_addr  = reg_addr_reg;
    assign o_reg_data  = reg_data_reg;
    assign o_busy      = (state_reg != IDLE);
    assign o_frame_err = frame_err_reg;

`ifdef I2C_TGT_SHADOW_EN
    logic [8:0] shadow_q [16];
    logic [8:0] rd_data_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
            logic [8:0] entry_reg;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    entry_reg <= '0;
                end else if (reg_wr_reg) begin
                    // Codec reset register clears the whole file
                    if (reg_addr_reg == 7'h0F) begin
                        entry_reg <= '0;
                    end else if (reg_addr_reg == 7'(gi)) begin
                        entry_reg <= reg_data_reg;
                    end
                end
            end
            assign shadow_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= shadow_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_reg;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^i_rd_addr;
    assign o_rd_data      = '0;
`endif

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed plus randomized bench for i2c_codec_target: bit-banged I2C initiator and a frame-level model.
`timescale 1ns/1ps
module tb_i2c_codec_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    wire        sda;
    logic       o_reg_wr;
    logic [6:0] o_reg_addr;
    logic [8:0] o_reg_data;
    logic       o_busy;
    logic       o_frame_err;
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] o_rd_data;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl),
        .io_sda     (sda),
        .o_reg_wr   (o_reg_wr),
        .o_reg_addr (o_reg_addr),
        .o_reg_data (o_reg_data),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (o_rd_data)
    );

    int total = 0;
    int bad   = 0;

    // Observation: strobes, frame errors and cycles where the target pulls SDA low
    logic [15:0] got_q[$];
    int          err_cnt = 0;
    int          dut_low = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_reg_wr) got_q.push_back({o_reg_addr, o_reg_data});
            if (o_frame_err) err_cnt++;
            if (sda === 1'b0 && !m_oe) dut_low++;
        end
    end

    // Frame-level reference model
    logic [15:0] exp_q[$];
    logic [8:0]  shadow_ref [16];
    int          got_base = 0;
    logic [7:0]  fb [4];
    int          fn;
    bit          ack [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
        exp_q.push_back({a, d});
        if (a == 7'h0F) begin
            for (int i = 0; i < 16; i++) shadow_ref[i] = '0;
        end else if (a < 7'd16) begin
            shadow_ref[a[3:0]] = d;
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic m_start();
        m_oe = 1'b0;
        wclk(10);
        scl = 1'b1;
        wclk(10);
        m_oe = 1'b1;
        wclk(10);
        scl = 1'b0;
    endtask

    task automatic m_bit(input bit b);
        wclk(10);
        m_oe = ~b;
        wclk(10);
        scl = 1'b1;
        wclk(20);
        scl = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b, output bit a);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        wclk(10);
        m_oe = 1'b0;
        wclk(10);
        scl = 1'b1;
        wclk(10);
        a = (sda === 1'b0);
        wclk(10);
        scl = 1'b0;
    endtask

    task automatic m_stop();
        wclk(10);
        m_oe = 1'b1;
        wclk(10);
        scl = 1'b1;
        wclk(10);
        m_oe = 1'b0;
        wclk(20);
    endtask

    task automatic do_frame();
        m_start();
        for (int i = 0; i < fn; i++) m_byte(fb[i], ack[i]);
        m_stop();
    endtask

    // Expected ACKs and strobe derived from the frame bytes alone
    task automatic check_frame(input string tag);
        bit match;
        match = (fb[0] == 8'h34);
        for (int i = 0; i < fn; i++)
            chk($sformatf("%s_ack%0d", tag, i), 32'(ack[i]), 32'(match && i < 3));
        if (match && fn >= 3) model_write(fb[1][7:1], {fb[1][0], fb[2]});
        chk({tag, "_strobes"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (got_base + i < got_q.size())
                chk({tag, "_strobe"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
        got_base = got_q.size();
        exp_q.delete();
        chk({tag, "_busy_after_stop"}, 32'(o_busy), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input int idx);
        logic [8:0] e;
        @(negedge clk);
        rd_addr = 4'(idx);
        @(negedge clk);
`ifdef I2C_TGT_SHADOW_EN
        e = shadow_ref[idx];
`else
        e = '0;
`endif
        chk(tag, 32'(o_rd_data), 32'(e));
    endtask

    task automatic set_fb(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input int n);
        fb[0] = a; fb[1] = b; fb[2] = c; fb[3] = d; fn = n;
    endtask

    initial begin
        int e0, l0;
        bit a_tmp;
        for (int i = 0; i < 16; i++) shadow_ref[i] = '0;

        // Reset values
        wclk(3);
        @(negedge clk);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_wr", 32'(o_reg_wr), 32'd0);
        chk("rst_addr", 32'(o_reg_addr), 32'd0);
        chk("rst_data", 32'(o_reg_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_frame_err), 32'd0);
        chk("rst_rd", 32'(o_rd_data), 32'd0);
        rst_n = 1'b1;
        wclk(10);

        // Two back-to-back codec writes
        e0 = err_cnt;
        set_fb(8'h34, 8'h1E, 8'h00, 8'h00, 3);
        m_start();
        wclk(8);
        chk("busy_in_frame", 32'(o_busy), 32'd1);
        for (int i = 0; i < fn; i++) m_byte(fb[i], ack[i]);
        m_stop();
        check_frame("f1");
        set_fb(8'h34, 8'h0C, 8'h9F, 8'h00, 3);
        do_frame();
        check_frame("f2");
        chk("f2_addr_hold", 32'(o_reg_addr), 32'h06);
        rd_chk("rd_shadow6", 6);
        chk("f12_no_err", 32'(err_cnt - e0), 32'd0);

        // Wrong address and read request: never driven, no strobe, no error
        e0 = err_cnt;
        l0 = dut_low;
        set_fb(8'h36, 8'h0C, 8'h00, 8'h00, 2);
        do_frame();
        check_frame("addr36");
        set_fb(8'h35, 8'h0C, 8'h00, 8'h00, 2);
        do_frame();
        check_frame("addr35");
        chk("nomatch_no_drive", 32'(dut_low - l0), 32'd0);
        chk("nomatch_no_err", 32'(err_cnt - e0), 32'd0);

        // Four-byte frame: extra byte NACKed, registers hold
        set_fb(8'h34, 8'h08, 8'h12, 8'h55, 4);
        do_frame();
        check_frame("four");
        chk("four_addr_hold", 32'(o_reg_addr), 32'h04);
        chk("four_data_hold", 32'(o_reg_data), 32'h012);

        // Repeated START after 5 bits of byte 2
        e0 = err_cnt;
        m_start();
        m_byte(8'h34, a_tmp);
        m_byte(8'h0A, a_tmp);
        for (int i = 7; i >= 3; i--) m_bit(1'(8'h06 >> i));
        set_fb(8'h34, 8'h0A, 8'h06, 8'h00, 3);
        do_frame();
        check_frame("rstart");
        chk("rstart_err_pulse", 32'(err_cnt - e0), 32'd1);

        // Reset while the target holds ACK low
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(1'(8'h34 >> i));
        m_oe = 1'b0;
        wclk(8);
        @(negedge clk);
        chk("ack_driven_before_rst", 32'(sda), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_release", 32'(sda), 32'd1);
        chk("rst_mid_addr", 32'(o_reg_addr), 32'd0);
        chk("rst_mid_data", 32'(o_reg_data), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_rd", 32'(o_rd_data), 32'd0);
        for (int i = 0; i < 16; i++) shadow_ref[i] = '0;
        wclk(4);
        @(negedge clk);
        rst_n = 1'b1;
        wclk(5);
        scl = 1'b1;
        wclk(20);
        set_fb(8'h34, 8'h12, 8'h01, 8'h00, 3);
        do_frame();
        check_frame("post_rst");

        // Codec reset register clears the shadow file
        set_fb(8'h34, 8'h08, 8'hAA, 8'h00, 3);
        do_frame();
        check_frame("wr4");
        rd_chk("rd_shadow4_set", 4);
        set_fb(8'h34, 8'h1E, 8'h00, 8'h00, 3);
        do_frame();
        check_frame("wr0f");
        rd_chk("rd_shadow4_clr", 4);

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            logic [6:0] ra;
            logic [8:0] rd;
            ra = (k % 3 == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
            if (ra == 7'h0F && k != 5) ra = 7'h0E;
            rd = 9'($urandom);
            set_fb((k == 4) ? 8'h36 : 8'h34, {ra, rd[8]}, rd[7:0], 8'($urandom),
                   ($urandom_range(0, 1) == 1) ? 4 : 3);
            do_frame();
            check_frame($sformatf("rnd%0d", k));
            rd_chk($sformatf("rnd%0d_rd", k), int'(ra[3:0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
